// File: rtl/seq_adder_ctrl.sv
// Sequential 64-bit adder: one SLICE_W-bit ripple slice reused over BEATS cycles, LSB first.
// Optional signed-overflow output enabled by defining SEQ_ADDER_OVERFLOW_EN.
module seq_adder_ctrl #(
  parameter int unsigned SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] sum,
  output logic        cout,
`ifdef SEQ_ADDER_OVERFLOW_EN
  output logic        ovf,
`endif
  output logic        busy
);

  localparam int unsigned BEATS = 64 / SLICE_W;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [63:0]        a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SLICE_W-1:0] a_sl, b_sl, slice_sum;
  logic               slice_cout;
  logic               last_beat;
`ifdef SEQ_ADDER_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  // The single shared ripple slice.
  always_comb begin
    a_sl = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
    b_sl = b_q[int'(idx_q) * SLICE_W +: SLICE_W];
    {slice_cout, slice_sum} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry_q};
    last_beat = (idx_q == IDX_W'(BEATS - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef SEQ_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          carry_d = cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[int'(idx_q) * SLICE_W +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (last_beat) begin
          cout_d  = slice_cout;
`ifdef SEQ_ADDER_OVERFLOW_EN
          // Top slice's MSB is sum[63] on the final beat.
          ovf_d   = (a_q[63] == b_q[63]) && (slice_sum[SLICE_W-1] != a_q[63]);
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef SEQ_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef SEQ_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // in_ready is masked by rst so it reads low throughout reset.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SEQ_ADDER_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_adder_ctrl.sv
// Directed bench for seq_adder_ctrl (SLICE_W = 16): vector table plus reset, backpressure
// and mid-run reset sequences. Checks ovf when SEQ_ADDER_OVERFLOW_EN is defined.
module tb_seq_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in1 = '0;
  logic [63:0] in2 = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] sum;
  logic        cout;
  logic        busy;
`ifdef SEQ_ADDER_OVERFLOW_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[8];

  seq_adder_ctrl #(.SLICE_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SEQ_ADDER_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int cyc;
    in1       = vecs[i].a;
    in2       = vecs[i].b;
    cin       = vecs[i].c;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk($sformatf("v%0d in_ready", i), {63'd0, in_ready}, 64'd1);
    tick();
    // Scramble operands while running; they must be ignored.
    in_valid = 1'b0;
    in1      = ~vecs[i].a;
    in2      = ~vecs[i].b;
    cin      = ~vecs[i].c;
    cyc      = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk($sformatf("v%0d latency", i), 64'(cyc), 64'd4);
    chk($sformatf("v%0d sum", i), sum, vecs[i].s);
    chk($sformatf("v%0d cout", i), {63'd0, cout}, {63'd0, vecs[i].co});
`ifdef SEQ_ADDER_OVERFLOW_EN
    chk($sformatf("v%0d ovf", i), {63'd0, ovf}, {63'd0, vecs[i].ov});
`endif
    tick();
    chk($sformatf("v%0d idle_after_hs", i), {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[2] = '{64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[7] = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFF, 1'b1,
                64'h0000_0000_0001_FFFF, 1'b0, 1'b0};

    // Reset held for three cycles.
    #2 rst = 1'b1;
    tick();
    tick();
    tick();
    chk("rst sum", sum, 64'd0);
    chk("rst cout", {63'd0, cout}, 64'd0);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 8; i++) begin
      run_vec(i);
    end

    // Backpressure: result held for 10 cycles while new requests are ignored.
    in1       = 64'd3;
    in2       = 64'd4;
    cin       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    cyc      = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("bp latency", 64'(cyc), 64'd4);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in1      = 64'h1000 + 64'(k);
      in2      = 64'h2000;
      chk("bp out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp sum", sum, 64'd7);
      chk("bp cout", {63'd0, cout}, 64'd0);
      chk("bp in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    // in_valid on the handshake edge must not start a new op.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp hs busy", {63'd0, busy}, 64'd0);
    chk("bp hs out_valid", {63'd0, out_valid}, 64'd0);
    chk("bp hs in_ready", {63'd0, in_ready}, 64'd1);
    chk("bp hs sum_kept", sum, 64'd7);
    tick();
    chk("bp no_new_op", {63'd0, busy}, 64'd0);

    // Reset mid-RUN on beat 2.
    in1      = 64'hFFFF_FFFF_FFFF_FFFF;
    in2      = 64'd1;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid async busy", {63'd0, busy}, 64'd0);
    chk("mid async sum", sum, 64'd0);
    chk("mid async in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid post in_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mid out_valid_low", {63'd0, out_valid}, 64'd0);
    end
    run_vec(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
